alu_mul_seq: RTL and testbench
==============================

// Module: alu_mul_seq
// PURPOSE
//   Multi-cycle unsigned 16x16->32 multiply sequencer in the execute stage.
//   Uses the shared 16-bit ALU's ADD operation as a shift-add datapath, one iteration per cycle.
//   Holds the pipeline via o_busy while running, then presents a 32-bit product and Z/N/C flags.
//   The ALU stays external; this block drives the ALU's operand and opcode ports and reads back its result and carry.
// PARAMETERS
//   WIDTH   16   operand width; must equal ALU width. Product is 2*WIDTH. Iterations = WIDTH.
// PORTS
//   i_clk             in   1      clock, rising edge
//   i_rst_n           in   1      asynchronous active-low reset
//   i_start           in   1      request multiply; accepted only when o_ready=1
//   i_flush           in   1      synchronous abort (pipeline flush)
//   i_multiplicand    in   WIDTH  operand A, sampled on accept
//   i_multiplier      in   WIDTH  operand B, sampled on accept
//   o_alu_data_1      out  WIDTH  to ALU i_data_1
//   o_alu_data_2      out  WIDTH  to ALU i_data_2
//   o_alu_op          out  3      to ALU i_op
//   i_alu_result      in   WIDTH  from ALU o_result
//   i_alu_carry       in   1      from ALU o_carry_flag
//   o_ready           out  1      can accept i_start this cycle
//   o_busy            out  1      stall request to hazard unit
//   o_valid           out  1      one-cycle pulse: product and flags valid
//   o_result_hi       out  WIDTH  product[2W-1:W]
//   o_result_lo       out  WIDTH  product[W-1:0]
//   o_zero_flag       out  1      product == 0
//   o_negative_flag   out  1      product[2W-1]
//   o_carry_flag      out  1      product overflows WIDTH (o_result_hi != 0)
// BEHAVIOUR
//   Reset (async, i_rst_n=0): state IDLE. acc, mplier, mcand, count, o_result_*, and all flags = 0.
//     o_valid=0, o_busy=0, o_ready=1, o_alu_op=3'b000.
//   States:
//     IDLE: o_ready=1, o_busy=0.
//     RUN:  o_ready=0, o_busy=1.
//     DONE: o_ready=1, o_busy=0, o_valid=1.
//   Accept (i_start & o_ready & !i_flush) in IDLE or DONE:
//     acc<=0, mplier<=i_multiplier, mcand<=i_multiplicand, count<=0, go to RUN.
//     Back-to-back accept in DONE is legal.
//   RUN, every cycle:
//     o_alu_op=3'b010 (ADD), o_alu_data_1=acc, o_alu_data_2 = mplier[0] ? mcand : 0.
//     Next: {acc, mplier} <= {i_alu_carry, i_alu_result, mplier} >> 1 (low bit dropped); count<=count+1.
//     After count==WIDTH-1 is processed, go to DONE.
//   Latency: accept at edge T -> o_valid high in cycle T+WIDTH+1 (T+17 for WIDTH=16).
//   DONE: o_result_hi/lo <= {acc, mplier} and flags registered on the RUN->DONE edge.
//     Outputs hold until the next DONE; only o_valid pulses.
//     Without i_start, DONE -> IDLE after one cycle.
//   Outside RUN: o_alu_op=3'b000, o_alu_data_1/2 = 0. The ALU preserves flags on NOP.
//   i_flush: any state -> IDLE next edge. No o_valid. o_result_*/flags keep old values.
//     i_flush wins over simultaneous i_start (request dropped).
//   i_start while o_ready=0 is ignored (no queueing).
//   Async reset mid-RUN aborts immediately to reset values.
//   Arithmetic is unsigned only. acc+addend carry is captured via ALU carry into bit WIDTH before the shift; no bits are lost.
// CONFIGURATION
//   MUL_ZERO_SKIP_EN defined:
//     On accept, if i_multiplicand==0 or i_multiplier==0, go directly to DONE.
//     Result 0, Z=1, N=0, C=0; o_valid at T+1. The ALU is not driven (op stays 000).
//   MUL_ZERO_SKIP_EN undefined:
//     Zero operands take the full WIDTH iterations. Result is identical.
// STRUCTURE
//   Shared defines file alu_defs.vh holds:
//     ALU opcode constants (ALU_OP_NOP=3'b000, ALU_OP_ADD=3'b010).
//     State encodings (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2).
//   No sub-module. The iteration counter, shift register and FSM are inline. The ALU is instantiated by the parent.
// TESTING (bench instantiates alu_mul_seq + alu)
//   3 x 5, start at T -> o_valid only at T+17: hi=0x0000, lo=0x000F, Z=0, N=0, C=0.
//   0xFFFF x 0xFFFF -> hi=0xFFFE, lo=0x0001, N=1, C=1. Exercises ALU carry every iteration.
//   Start, then i_flush at T+8 -> no o_valid, o_ready=1 at T+9, previous result unchanged.
//   i_start asserted in the DONE cycle (0x0100 x 0x0100) -> accepted, next o_valid 17 cycles later: hi=0x0001, lo=0x0000.
//   Zero operand (0 x 0x1234):
//     with MUL_ZERO_SKIP_EN -> o_valid at T+1, Z=1.
//     without MUL_ZERO_SKIP_EN -> T+17, Z=1.
//   i_rst_n low mid-RUN -> outputs at reset values immediately. i_start ignored while busy.

Source files
------------

// File: rtl/alu_mul_seq_pkg.sv
// Shared constants and state encoding for the shift-add multiply sequencer.
package alu_mul_seq_pkg;

    // Opcodes understood by the shared execute-stage ALU.
    localparam int         ALU_OP_W   = 3;
    localparam logic [2:0] ALU_OP_NOP = 3'b000;
    localparam logic [2:0] ALU_OP_ADD = 3'b010;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

endpackage : alu_mul_seq_pkg

// File: rtl/alu_mul_seq.sv
// Multi-cycle unsigned WIDTH x WIDTH -> 2*WIDTH multiplier that borrows the
// external execute-stage ALU as its adder, one shift-add iteration per cycle.
// Optional feature: define MUL_ZERO_SKIP_EN to finish immediately when either
// operand is zero instead of running all WIDTH iterations.
module alu_mul_seq
    import alu_mul_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic                i_flush,
    input  logic [WIDTH-1:0]    i_multiplicand,
    input  logic [WIDTH-1:0]    i_multiplier,
    output logic [WIDTH-1:0]    o_alu_data_1,
    output logic [WIDTH-1:0]    o_alu_data_2,
    output logic [ALU_OP_W-1:0] o_alu_op,
    input  logic [WIDTH-1:0]    i_alu_result,
    input  logic                i_alu_carry,
    output logic                o_ready,
    output logic                o_busy,
    output logic                o_valid,
    output logic [WIDTH-1:0]    o_result_hi,
    output logic [WIDTH-1:0]    o_result_lo,
    output logic                o_zero_flag,
    output logic                o_negative_flag,
    output logic                o_carry_flag
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    mul_state_e         state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   res_hi_q, res_hi_d;
    logic [WIDTH-1:0]   res_lo_q, res_lo_d;
    logic               zero_q, zero_d;
    logic               neg_q, neg_d;
    logic               carry_q, carry_d;

    logic               running;
    logic               accept;
    logic               last_iter;
    logic [2*WIDTH-1:0] shifted;

    assign running   = (state_q == ST_RUN);
    assign accept    = i_start && !running && !i_flush;
    assign last_iter = (count_q == CNT_W'(WIDTH - 1));

    // {carry, sum, mplier} shifted right by one: the ALU carry lands in the
    // accumulator MSB so no product bit is lost, and mplier[0] is consumed.
    assign shifted = {i_alu_carry, i_alu_result, mplier_q[WIDTH-1:1]};

    // Status and ALU drive; the ALU only sees a real operation while running.
    always_comb begin
        o_ready         = !running;
        o_busy          = running;
        o_valid         = (state_q == ST_DONE);
        o_alu_op        = running ? ALU_OP_ADD : ALU_OP_NOP;
        o_alu_data_1    = running ? acc_q : '0;
        o_alu_data_2    = (running && mplier_q[0]) ? mcand_q : '0;
        o_result_hi     = res_hi_q;
        o_result_lo     = res_lo_q;
        o_zero_flag     = zero_q;
        o_negative_flag = neg_q;
        o_carry_flag    = carry_q;
    end

    // Next-state and datapath update.
    always_comb begin
        // NOTE: every signal assigned here gets a hold default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d  = state_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        mcand_d  = mcand_q;
        count_d  = count_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        carry_d  = carry_q;

        if (i_flush) begin
            // Abort: results and flags keep their previous values.
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        acc_d    = '0;
                        mplier_d = i_multiplier;
                        mcand_d  = i_multiplicand;
                        count_d  = '0;
                        state_d  = ST_RUN;
`ifdef MUL_ZERO_SKIP_EN
                        if ((i_multiplicand == '0) || (i_multiplier == '0)) begin
                            state_d  = ST_DONE;
                            res_hi_d = '0;
                            res_lo_d = '0;
                            zero_d   = 1'b1;
                            neg_d    = 1'b0;
                            carry_d  = 1'b0;
                        end
`endif
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    {acc_d, mplier_d} = shifted;
                    count_d           = count_q + 1'b1;
                    if (last_iter) begin
                        state_d  = ST_DONE;
                        res_hi_d = shifted[2*WIDTH-1:WIDTH];
                        res_lo_d = shifted[WIDTH-1:0];
                        zero_d   = (shifted == '0);
                        neg_d    = shifted[2*WIDTH-1];
                        carry_d  = (shifted[2*WIDTH-1:WIDTH] != '0);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (!i_rst_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Datapath and result registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_q    <= '0;
            mplier_q <= '0;
            mcand_q  <= '0;
            count_q  <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            carry_q  <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            mcand_q  <= mcand_d;
            count_q  <= count_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            carry_q  <= carry_d;
        end
    end

endmodule : alu_mul_seq

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq with a behavioural stand-in for the
// shared ALU. Expected products come from plain integer multiplication.
// Latency expectations follow MUL_ZERO_SKIP_EN when it is defined.
module tb_alu_mul_seq;

    localparam int W = 16;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          flush;
    logic [W-1:0]  mcand;
    logic [W-1:0]  mplier;
    logic [W-1:0]  alu_d1;
    logic [W-1:0]  alu_d2;
    logic [2:0]    alu_op;
    logic [W-1:0]  alu_res;
    logic          alu_c;
    logic          ready;
    logic          busy;
    logic          valid;
    logic [W-1:0]  res_hi;
    logic [W-1:0]  res_lo;
    logic          zf;
    logic          nf;
    logic          cf;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2*W-1:0] last_prod;
    logic           last_z;
    logic           last_n;
    logic           last_c;

    alu_mul_seq #(.WIDTH(W)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_start         (start),
        .i_flush         (flush),
        .i_multiplicand  (mcand),
        .i_multiplier    (mplier),
        .o_alu_data_1    (alu_d1),
        .o_alu_data_2    (alu_d2),
        .o_alu_op        (alu_op),
        .i_alu_result    (alu_res),
        .i_alu_carry     (alu_c),
        .o_ready         (ready),
        .o_busy          (busy),
        .o_valid         (valid),
        .o_result_hi     (res_hi),
        .o_result_lo     (res_lo),
        .o_zero_flag     (zf),
        .o_negative_flag (nf),
        .o_carry_flag    (cf)
    );

    // Behavioural ALU: ADD yields sum and carry-out, anything else yields zero.
    always_comb begin
        if (alu_op == 3'b010) {alu_c, alu_res} = {1'b0, alu_d1} + {1'b0, alu_d2};
        else                  {alu_c, alu_res} = '0;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Edges from accept until o_valid is visible.
    function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MUL_ZERO_SKIP_EN
        if (a == '0 || b == '0) return 0;
`endif
        return W;
    endfunction

    // Issue one multiply (driven at the negedge before the accept edge) and
    // check latency, product and flags. With poke set, a stray i_start is
    // raised mid-run and must be ignored.
    task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b, input bit poke);
        logic [2*W-1:0] p;
        int             lat;
        int             n;
        p   = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        lat = exp_lat(a, b);
        @(negedge clk);
        start  = 1'b1;
        mcand  = a;
        mplier = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        n     = 0;
        if (lat != 0) check("busy_after_accept", busy, 1);
        while (!valid && n < 40) begin
            if (poke && n == 5) begin
                start  = 1'b1;
                mcand  = W'($urandom);
                mplier = W'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b0;
        check("latency", n, lat);
        check("result_hi", res_hi, p[2*W-1:W]);
        check("result_lo", res_lo, p[W-1:0]);
        check("zero_flag", zf, (p == '0));
        check("neg_flag", nf, p[2*W-1]);
        check("carry_flag", cf, (p[2*W-1:W] != '0));
        check("ready_in_done", ready, 1);
        last_prod = p;
        last_z    = (p == '0);
        last_n    = p[2*W-1];
        last_c    = (p[2*W-1:W] != '0);
    endtask

    // One cycle with no request: DONE must drop back to IDLE and hold results.
    task automatic idle_cycle();
        @(posedge clk);
        #1;
        check("valid_pulse_ends", valid, 0);
        check("idle_ready", ready, 1);
        check("idle_hold_hi", res_hi, last_prod[2*W-1:W]);
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           vseen;

        rst_n  = 1'b0;
        start  = 1'b0;
        flush  = 1'b0;
        mcand  = '0;
        mplier = '0;
        last_prod = '0;
        last_z = 1'b0;
        last_n = 1'b0;
        last_c = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        check("rst_alu_op", alu_op, 0);
        check("rst_alu_data", {alu_d1, alu_d2}, 0);
        check("rst_result", {res_hi, res_lo}, 0);
        check("rst_flags", {zf, nf, cf}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases.
        run_mul(16'd3, 16'd5, 1'b0);
        idle_cycle();
        run_mul(16'hFFFF, 16'hFFFF, 1'b0);
        idle_cycle();
        run_mul(16'h1234, 16'h0002, 1'b0);
        run_mul(16'h0100, 16'h0100, 1'b0);     // accepted in the DONE cycle
        idle_cycle();
        run_mul(16'h0000, 16'h1234, 1'b0);
        idle_cycle();
        run_mul(16'hABCD, 16'h0000, 1'b0);
        idle_cycle();

        // Flush at accept+8: no result, old product retained.
        run_mul(16'h00C3, 16'h0101, 1'b0);
        idle_cycle();
        @(negedge clk);
        start  = 1'b1;
        mcand  = 16'h7777;
        mplier = 16'h3333;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_ready", ready, 1);
        check("flush_busy", busy, 0);
        check("flush_valid", valid, 0);
        check("flush_alu_op", alu_op, 0);
        check("flush_keep_result", {res_hi, res_lo}, last_prod);
        check("flush_keep_flags", {zf, nf, cf}, {last_z, last_n, last_c});
        vseen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (valid) vseen++;
        end
        check("flush_no_valid", vseen, 0);

        // Flush together with start: request dropped.
        @(negedge clk);
        start  = 1'b1;
        flush  = 1'b1;
        mcand  = 16'h0003;
        mplier = 16'h0003;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        check("flush_start_busy", busy, 0);
        check("flush_start_ready", ready, 1);

        // Stray start while busy must not disturb the running product.
        run_mul(16'h4321, 16'h8765, 1'b1);
        idle_cycle();

        // Async reset mid-run.
        @(negedge clk);
        start  = 1'b1;
        mcand  = 16'h9999;
        mplier = 16'h8888;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_ready", ready, 1);
        check("midrst_valid", valid, 0);
        check("midrst_alu_op", alu_op, 0);
        check("midrst_result", {res_hi, res_lo}, 0);
        check("midrst_flags", {zf, nf, cf}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        last_prod = '0;
        last_z = 1'b0;
        last_n = 1'b0;
        last_c = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_valid", valid, 0);

        // Randomised operands, mixing back-to-back and idle-separated runs.
        for (int i = 0; i < 24; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            if ($urandom_range(0, 5) == 0) a = '0;
            if ($urandom_range(0, 5) == 0) b = '0;
            run_mul(a, b, 1'b0);
            if (i % 3 == 0) idle_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_alu_mul_seq
